inst_loader: RTL

//  Boot-time program loader feeding the instruction memory write port of the fetch units.

---
 rtl/inst_loader_pkg.sv | 21 ++
 rtl/inst_loader_if.sv | 34 +++
 rtl/inst_loader_word_assembler.sv | 38 +++
 rtl/inst_loader.sv | 127 ++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg
//   Constants and the state type shared by the boot loader files.
//   LOADER_ADDR_WIDTH      default instruction memory address width (words)
//   INST_MEM_WIDTH         instruction word width in bits
//   LOADER_BYTES_PER_WORD  received bytes per instruction word
//   loader_state_t         loader FSM state encoding
package inst_loader_pkg;

  localparam int LOADER_ADDR_WIDTH     = 14;
  localparam int INST_MEM_WIDTH        = 32;
  localparam int LOADER_BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    HEADER,
    BODY,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/inst_loader_if.sv
// inst_loader_if
//   Byte-stream input and instruction memory write port of the boot loader.
//   master : loader side (accepts rx bytes, drives memory write and core control)
//   slave  : environment side (UART receiver, instruction memory, cores)
//   Signals: rx_data/rx_valid/rx_ready byte handshake; mem_we/mem_addr/mem_wdata
//   write port; hold, start, error, words_loaded status.
interface inst_loader_if
  import inst_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = LOADER_ADDR_WIDTH
) ();

  logic [7:0]                rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [INST_MEM_WIDTH-1:0] mem_wdata;
  logic                      hold;
  logic                      start;
  logic                      error;
  logic [ADDR_WIDTH:0]       words_loaded;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, hold, start, error, words_loaded
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, hold, start, error, words_loaded
  );

endinterface

// File: rtl/inst_loader_word_assembler.sv
// word_assembler
//   Packs accepted bytes into big-endian instruction words: the first byte
//   lands in bits [31:24], the fourth byte completes the word.
//   clk, reset   clock, synchronous active-high reset
//   byte_in      received byte
//   byte_valid   byte accepted this cycle (handshake already qualified)
//   word         assembled word, valid while word_done is high
//   word_done    high on the handshake of the fourth byte
module word_assembler
  import inst_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                byte_in,
  input  logic                      byte_valid,
  output logic [INST_MEM_WIDTH-1:0] word,
  output logic                      word_done
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift_q  <= {shift_q[15:0], byte_in};
    end
  end

  // The final byte is used straight from the input so the word is available
  // in the handshake cycle itself.
  assign word      = {shift_q, byte_in};
  assign word_done = byte_valid && (byte_cnt == 2'(LOADER_BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_loader.sv
// inst_loader
//   Boot-time program loader. Receives a header word N, then N big-endian
//   words which are written to instruction memory from address 0 while the
//   cores are held. A single start pulse releases the cores afterwards.
//   clk, reset   clock, synchronous active-high reset
//   bus          inst_loader_if.master: rx byte handshake, memory write port,
//                hold/start/error/words_loaded
//   Build option: define LOADER_CHECKSUM_EN to require a trailing 32-bit word
//   equal to the sum (mod 2**32) of all body words before start is issued.
//
//   state  | meaning
//   HEADER | collecting the 4-byte word count N
//   BODY   | collecting words, one memory write per completed word
//   CHECK  | collecting the checksum word (LOADER_CHECKSUM_EN only)
//   DONE   | image loaded, cores released; waits for reset
//   ERROR  | bad length or checksum; cores stay held until reset
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = LOADER_ADDR_WIDTH
) (
  input logic         clk,
  input logic         reset,
  inst_loader_if.master bus
);

  localparam logic [INST_MEM_WIDTH-1:0] CAPACITY = INST_MEM_WIDTH'(1) << ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t POST_BODY = CHECK;
`else
  localparam loader_state_t POST_BODY = DONE;
`endif

  loader_state_t             state, state_next;
  logic                      hs;
  logic [INST_MEM_WIDTH-1:0] asm_word;
  logic                      asm_done;
  logic [ADDR_WIDTH:0]       n_words;
  logic [ADDR_WIDTH:0]       words_loaded_q;
  logic                      mem_we_q;
  logic [ADDR_WIDTH-1:0]     mem_addr_q;
  logic [INST_MEM_WIDTH-1:0] mem_wdata_q;
  logic                      start_q;
  logic                      last_write;
`ifdef LOADER_CHECKSUM_EN
  logic [INST_MEM_WIDTH-1:0] sum_q;
`endif

  assign bus.rx_ready = (state == HEADER) || (state == BODY) || (state == CHECK);
  assign hs           = bus.rx_valid && bus.rx_ready;

  word_assembler u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .byte_in   (bus.rx_data),
    .byte_valid(hs),
    .word      (asm_word),
    .word_done (asm_done)
  );

  // words_loaded advances together with mem_we, so equality here means the
  // write of word N-1 is on the bus this cycle.
  assign last_write = mem_we_q && (words_loaded_q == n_words);

  always_comb begin
    state_next = state;
    case (state)
      HEADER: begin
        if (asm_done) begin
          if (asm_word == '0)          state_next = POST_BODY;
          else if (asm_word > CAPACITY) state_next = ERROR;
          else                         state_next = BODY;
        end
      end
      BODY: begin
        if (last_write) state_next = POST_BODY;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (asm_done) state_next = (asm_word == sum_q) ? DONE : ERROR;
      end
`endif
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= HEADER;
      n_words        <= '0;
      words_loaded_q <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      start_q        <= 1'b0;
    end else begin
      state    <= state_next;
      start_q  <= (state_next == DONE) && (state != DONE);
      mem_we_q <= (state == BODY) && asm_done;
      // Range check has already passed when BODY is entered, so the low
      // ADDR_WIDTH+1 bits hold N exactly.
      if ((state == HEADER) && asm_done) n_words <= asm_word[ADDR_WIDTH:0];
      if ((state == BODY) && asm_done) begin
        mem_addr_q     <= words_loaded_q[ADDR_WIDTH-1:0];
        mem_wdata_q    <= asm_word;
        words_loaded_q <= words_loaded_q + 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)                       sum_q <= '0;
    else if ((state == BODY) && asm_done) sum_q <= sum_q + asm_word;
  end
`endif

  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.start        = start_q;
  assign bus.hold         = (state != DONE);
  assign bus.error        = (state == ERROR);
  assign bus.words_loaded = words_loaded_q;

endmodule
